// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR resynchronisation controller.
//   state_e : controller FSM states
//   cls_e   : per-cycle replica classification (agree / single / multi)
//   LANE_*  : lane indices; LANE_MULTI marks "no two replicas equal"
//   lane_onehot() : lane index to one-hot load strobe
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_MONITOR = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_LOAD    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_AGREE  = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } cls_e;

    localparam logic [1:0] LANE_A     = 2'd0;
    localparam logic [1:0] LANE_B     = 2'd1;
    localparam logic [1:0] LANE_C     = 2'd2;
    localparam logic [1:0] LANE_MULTI = 2'd3;

    // LANE_MULTI (or anything else) maps to no strobe at all.
    function automatic logic [2:0] lane_onehot(input logic [1:0] lane);
        logic [2:0] oh;
        case (lane)
            LANE_A:  oh = 3'b001;
            LANE_B:  oh = 3'b010;
            LANE_C:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tmr_voter.sv
// Combinational 2-of-3 voter and replica classifier.
//   i_a/i_b/i_c : replica counts (lanes 0/1/2)
//   o_voted     : bitwise majority
//   o_cls       : AGREE, SINGLE (exactly one lane differs) or MULTI
//   o_lane      : divergent lane for SINGLE, LANE_MULTI for MULTI, LANE_A for AGREE
module tmr_voter
    import tmr_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_voted,
    output cls_e             o_cls,
    output logic [1:0]       o_lane
);

    logic ab_eq_s;
    logic ac_eq_s;
    logic bc_eq_s;

    // Majority vote and pairwise-equality based classification.
    always_comb begin
        o_voted = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
        ab_eq_s = (i_a == i_b);
        ac_eq_s = (i_a == i_c);
        bc_eq_s = (i_b == i_c);
        o_cls   = CLS_AGREE;
        o_lane  = LANE_A;
        if (ab_eq_s && bc_eq_s) begin
            o_cls  = CLS_AGREE;
            o_lane = LANE_A;
        end else if (ab_eq_s) begin
            o_cls  = CLS_SINGLE;
            o_lane = LANE_C;
        end else if (ac_eq_s) begin
            o_cls  = CLS_SINGLE;
            o_lane = LANE_B;
        end else if (bc_eq_s) begin
            o_cls  = CLS_SINGLE;
            o_lane = LANE_A;
        end else begin
            o_cls  = CLS_MULTI;
            o_lane = LANE_MULTI;
        end
    end

endmodule

// File: rtl/tmr_resync_ctrl.sv
// Majority-vote and resynchronisation controller for a triplicated counter.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_en                    : enables mismatch detection
//   i_count_a/b/c           : replica counts, lanes 0/1/2
//   i_clr_fault             : leaves the sticky FAULT state
//   o_voted                 : combinational 2-of-3 majority
//   o_load / o_load_val     : one-hot reload strobe and value for the repaired lane
//   o_busy                  : high while confirming or repairing
//   o_fault / o_fault_lane  : sticky fault and the faulted lane (3 = uncorrectable)
//   o_resync_count          : saturating count of issued LOAD cycles
module tmr_resync_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int CONFIRM   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_count_a,
    input  logic [WIDTH-1:0] i_count_b,
    input  logic [WIDTH-1:0] i_count_c,
    input  logic             i_clr_fault,
    output logic [WIDTH-1:0] o_voted,
    output logic [2:0]       o_load,
    output logic [WIDTH-1:0] o_load_val,
    output logic             o_busy,
    output logic             o_fault,
    output logic [1:0]       o_fault_lane,
    output logic [7:0]       o_resync_count
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] CONFIRM_C   = CW'(CONFIRM);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

    cls_e              cls_s;
    logic [1:0]        lane_s;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d;
    logic [1:0]        lane_q, lane_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [7:0]        resync_q, resync_d;
    logic [1:0]        fault_lane_q, fault_lane_d;

    tmr_voter #(.WIDTH(WIDTH)) u_voter (
        .i_a     (i_count_a),
        .i_b     (i_count_b),
        .i_c     (i_count_c),
        .o_voted (o_voted),
        .o_cls   (cls_s),
        .o_lane  (lane_s)
    );

    // State and bookkeeping registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_MONITOR;
            cls_q        <= CLS_AGREE;
            lane_q       <= LANE_A;
            cnt_q        <= '0;
            retry_q      <= '0;
            resync_q     <= 8'd0;
            fault_lane_q <= LANE_A;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            resync_q     <= resync_d;
            fault_lane_q <= fault_lane_d;
        end
    end

    // Next-state logic for the confirm/repair/fault sequence.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        resync_d     = resync_q;
        fault_lane_d = fault_lane_q;
        case (state_q)
            ST_MONITOR: begin
                if (i_en && (cls_s != CLS_AGREE)) begin
                    cls_d  = cls_s;
                    lane_d = lane_s;
                    cnt_d  = CW'(1);
                    if (CONFIRM_C == CW'(1)) begin
                        if (cls_s == CLS_MULTI) begin
                            state_d      = ST_FAULT;
                            fault_lane_d = LANE_MULTI;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_CONFIRM;
                    end
                end else begin
                    state_d = ST_MONITOR;
                end
            end
            ST_CONFIRM: begin
                if (!i_en || (cls_s == CLS_AGREE)) begin
                    state_d = ST_MONITOR;
                end else if ((cls_s != cls_q) || (lane_s != lane_q)) begin
                    // A different lane diverging counts as a new event.
                    cls_d  = cls_s;
                    lane_d = lane_s;
                    cnt_d  = CW'(1);
                end else if ((cnt_q + CW'(1)) == CONFIRM_C) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cls_q == CLS_MULTI) begin
                        state_d      = ST_FAULT;
                        fault_lane_d = LANE_MULTI;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOAD: begin
                retry_d  = retry_q + RW'(1);
                resync_d = (resync_q == 8'hFF) ? resync_q : (resync_q + 8'd1);
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (cls_s == CLS_AGREE) begin
                    state_d = ST_MONITOR;
                    retry_d = '0;
                end else if (retry_q == MAX_RETRY_C) begin
                    state_d      = ST_FAULT;
                    fault_lane_d = lane_q;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FAULT: begin
                if (i_clr_fault) begin
                    state_d = ST_MONITOR;
                    retry_d = '0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    // Moore outputs; the reload value anticipates the healthy lanes' increment.
    always_comb begin
        o_busy         = (state_q == ST_CONFIRM) || (state_q == ST_LOAD) ||
                         (state_q == ST_CHECK);
        o_fault        = (state_q == ST_FAULT);
        o_fault_lane   = fault_lane_q;
        o_resync_count = resync_q;
        if (state_q == ST_LOAD) begin
            o_load     = lane_onehot(lane_q);
            o_load_val = o_voted + WIDTH'(1);
        end else begin
            o_load     = 3'b000;
            o_load_val = '0;
        end
    end

endmodule

// File: tb/tb_tmr_resync_ctrl.sv
module tb_tmr_resync_ctrl;

    typedef struct {
        int         cyc;
        logic [2:0] ld;
        logic [1:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] rep [3];
    logic [1:0] voted;
    logic [2:0] ld;
    logic [1:0] ld_val;
    logic       busy;
    logic       fault;
    logic [1:0] fault_lane;
    logic [7:0] resync;

    // replica model state
    logic       run;
    logic       stuck [3];
    logic [1:0] stuck_val [3];
    logic       ignore_ld [3];
    logic [2:0] ld_s;
    logic [1:0] ldv_s;

    exp_t sb_q [$];
    int   total;
    int   bad;
    int   cyc_n;

    tmr_resync_ctrl #(.WIDTH(2), .CONFIRM(2), .MAX_RETRY(3)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .i_count_a      (rep[0]),
        .i_count_b      (rep[1]),
        .i_count_c      (rep[2]),
        .i_clr_fault    (clr),
        .o_voted        (voted),
        .o_load         (ld),
        .o_load_val     (ld_val),
        .o_busy         (busy),
        .o_fault        (fault),
        .o_fault_lane   (fault_lane),
        .o_resync_count (resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    // Active edge, then replicas update: load wins, else stuck, else count.
    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ld_s[i] && !ignore_ld[i]) begin
                rep[i]   = ldv_s;
                stuck[i] = 1'b0;
            end else if (stuck[i]) begin
                rep[i] = stuck_val[i];
            end else if (run) begin
                rep[i] = rep[i] + 2'd1;
            end
        end
    endtask

    // Mid-cycle sample; any load strobe is matched against the scoreboard.
    task automatic smp();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        ld_s  = ld;
        ldv_s = ld_val;
        if (ld !== 3'b000) begin
            if (sb_q.size() == 0) begin
                chk("unexp_load", {29'd0, ld}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("load_cyc", cyc_n, e.cyc);
                chk("load", {29'd0, ld}, {29'd0, e.ld});
                chk("load_val", {30'd0, ld_val}, {30'd0, e.val});
            end
        end
    endtask

    task automatic push(input int c, input logic [2:0] l, input logic [1:0] v);
        exp_t e;
        e.cyc = c;
        e.ld  = l;
        e.val = v;
        sb_q.push_back(e);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc_n = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        run   = 1'b0;
        ld_s  = 3'b000;
        ldv_s = 2'd0;
        for (int i = 0; i < 3; i++) begin
            rep[i]       = 2'd1;
            stuck[i]     = 1'b0;
            stuck_val[i] = 2'd0;
            ignore_ld[i] = 1'b0;
        end

        // 1. reset state with 1/1/1
        adv();
        adv();
        rst_n = 1'b1;
        smp();
        chk("rst_voted", {30'd0, voted}, 32'd1);
        chk("rst_load", {29'd0, ld}, 32'd0);
        chk("rst_load_val", {30'd0, ld_val}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fault_lane", {30'd0, fault_lane}, 32'd0);
        chk("rst_resync", {24'd0, resync}, 32'd0);

        // 2. single-cycle glitch on lane B
        adv();
        en     = 1'b1;
        rep[1] = 2'd2;
        smp();
        chk("glitch_voted", {30'd0, voted}, 32'd1);
        chk("glitch_busy_n", {31'd0, busy}, 32'd0);
        adv();
        rep[1] = 2'd1;
        smp();
        chk("glitch_busy_n1", {31'd0, busy}, 32'd1);
        adv();
        smp();
        chk("glitch_busy_n2", {31'd0, busy}, 32'd0);
        chk("glitch_resync", {24'd0, resync}, 32'd0);

        // 3. lane B stuck at 3, counters running
        adv();
        run          = 1'b1;
        rep[0]       = 2'd0;
        rep[1]       = 2'd3;
        rep[2]       = 2'd0;
        stuck[1]     = 1'b1;
        stuck_val[1] = 2'd3;
        push(cyc_n + 3, 3'b010, 2'd3);
        smp();
        chk("b3_busy_n", {31'd0, busy}, 32'd0);
        adv();
        smp();
        chk("b3_busy_n1", {31'd0, busy}, 32'd1);
        adv();
        smp();
        chk("b3_busy_n2", {31'd0, busy}, 32'd1);
        adv();
        smp();
        chk("b3_check_voted", {30'd0, voted}, 32'd3);
        chk("b3_busy_n3", {31'd0, busy}, 32'd1);
        adv();
        smp();
        chk("b3_busy_n4", {31'd0, busy}, 32'd0);
        chk("b3_resync", {24'd0, resync}, 32'd1);

        // 4. wrap-around: reload value 3+1 -> 0
        adv();
        rep[0]       = 2'd1;
        rep[1]       = 2'd0;
        rep[2]       = 2'd1;
        stuck[1]     = 1'b1;
        stuck_val[1] = 2'd0;
        push(cyc_n + 3, 3'b010, 2'd0);
        smp();
        for (int k = 0; k < 3; k++) begin
            adv();
            smp();
        end
        chk("wrap_check_voted", {30'd0, voted}, 32'd0);
        chk("wrap_busy_n3", {31'd0, busy}, 32'd1);
        adv();
        smp();
        chk("wrap_busy_n4", {31'd0, busy}, 32'd0);
        chk("wrap_resync", {24'd0, resync}, 32'd2);

        // 5. lane C ignores its load -> three retries then FAULT lane 2
        adv();
        rep[0]       = 2'd0;
        rep[1]       = 2'd0;
        rep[2]       = 2'd2;
        ignore_ld[2] = 1'b1;
        push(cyc_n + 3, 3'b100, 2'd3);
        push(cyc_n + 5, 3'b100, 2'd1);
        push(cyc_n + 7, 3'b100, 2'd3);
        smp();
        for (int k = 0; k < 7; k++) begin
            adv();
            smp();
        end
        chk("c_busy_n7", {31'd0, busy}, 32'd1);
        chk("c_fault_n7", {31'd0, fault}, 32'd0);
        adv();
        smp();
        chk("c_fault", {31'd0, fault}, 32'd1);
        chk("c_fault_lane", {30'd0, fault_lane}, 32'd2);
        chk("c_busy_fault", {31'd0, busy}, 32'd0);
        chk("c_resync", {24'd0, resync}, 32'd5);
        adv();
        clr = 1'b1;
        smp();
        chk("c_fault_hold", {31'd0, fault}, 32'd1);
        adv();
        clr = 1'b0;
        en  = 1'b0;
        smp();
        chk("c_fault_clr", {31'd0, fault}, 32'd0);
        chk("c_busy_clr", {31'd0, busy}, 32'd0);
        chk("c_resync_kept", {24'd0, resync}, 32'd5);

        // 6a. 0/1/2 -> uncorrectable fault, no load
        adv();
        ignore_ld[2] = 1'b0;
        run          = 1'b0;
        rep[0]       = 2'd0;
        rep[1]       = 2'd1;
        rep[2]       = 2'd2;
        en           = 1'b1;
        smp();
        chk("m_busy_n", {31'd0, busy}, 32'd0);
        adv();
        smp();
        chk("m_busy_n1", {31'd0, busy}, 32'd1);
        adv();
        smp();
        chk("m_fault", {31'd0, fault}, 32'd1);
        chk("m_fault_lane", {30'd0, fault_lane}, 32'd3);
        chk("m_resync", {24'd0, resync}, 32'd5);
        adv();
        clr = 1'b1;
        en  = 1'b0;
        smp();
        adv();
        clr = 1'b0;
        smp();
        chk("m_fault_clr", {31'd0, fault}, 32'd0);

        // 6b. reset asserted in the middle of LOAD
        adv();
        run          = 1'b1;
        en           = 1'b1;
        rep[0]       = 2'd0;
        rep[1]       = 2'd3;
        rep[2]       = 2'd0;
        stuck[1]     = 1'b1;
        stuck_val[1] = 2'd3;
        push(cyc_n + 3, 3'b010, 2'd3);
        smp();
        adv();
        smp();
        adv();
        smp();
        chk("rl_in_load", {29'd0, ld}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rl_load_drop", {29'd0, ld}, 32'd0);
        chk("rl_load_val_drop", {30'd0, ld_val}, 32'd0);
        chk("rl_busy_drop", {31'd0, busy}, 32'd0);
        ld_s     = 3'b000;
        en       = 1'b0;
        run      = 1'b0;
        stuck[1] = 1'b0;
        rep[0]   = 2'd0;
        rep[1]   = 2'd0;
        rep[2]   = 2'd0;
        adv();
        rst_n = 1'b1;
        smp();
        chk("rl_resync_reset", {24'd0, resync}, 32'd0);
        chk("rl_busy_after", {31'd0, busy}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
